sram_port_arbiter: RTL

Shares one synchronous single-port SRAM between the CPU's instruction-fetch requester and data-access requester. Each requester uses a req/addr_ok/data_ok handshake. The arbiter grants at most one access per cycle, with data priority and a starvation bound for fetch. It tracks every in-flight access in a latency pipeline so each response goes back to the requester that issued it. It sits between the CPU core and a unified memory, replacing separate inst/data SRAM ports.

---
 rtl/cpu_bus_pkg.sv | 20 ++
 rtl/resp_tag_pipe.sv | 41 ++++
 rtl/sram_port_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: response tag, default arbiter parameters and bus width.
package cpu_bus_pkg;

  localparam int unsigned BUS_W            = 32;
  localparam int unsigned STRB_W           = BUS_W / 8;
  localparam int unsigned RD_LAT_DEF       = 1;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STREAK_W         = 4;

  typedef enum logic {
    TAG_INST = 1'b0,
    TAG_DATA = 1'b1
  } req_tag_e;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] val,
                                                  input logic [STREAK_W-1:0] limit);
    sat_inc = (val < limit) ? val + STREAK_W'(1) : limit;
  endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// Fixed-depth valid+tag shift register tracking in-flight SRAM accesses.
module resp_tag_pipe
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH = RD_LAT_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  input  req_tag_e in_tag,
  output logic     out_valid,
  output req_tag_e out_tag
);

  logic [DEPTH-1:0] valid_q, valid_d;
  req_tag_e         tag_q [DEPTH];
  req_tag_e         tag_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    tag_d[0]   = in_tag;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= TAG_INST;
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one single-port SRAM,
// data-priority with a fetch starvation bound, responses routed by tag pipeline.
module sram_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RD_LAT       = RD_LAT_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [BUS_W-1:0]  inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [BUS_W-1:0]  inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [BUS_W-1:0]  data_addr,
  input  logic [BUS_W-1:0]  data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [BUS_W-1:0]  data_rdata,
  output logic              sram_en,
  output logic [STRB_W-1:0] sram_we,
  output logic [BUS_W-1:0]  sram_addr,
  output logic [BUS_W-1:0]  sram_wdata,
  input  logic [BUS_W-1:0]  sram_rdata
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                grant_inst, grant_data;
  logic                resp_valid;
  req_tag_e            resp_tag;
  req_tag_e            issue_tag;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset) begin
      if (inst_req && data_req) begin
        if (streak_q == STREAK_LIM) grant_inst = 1'b1;
        else                        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end
    end
  end

  // The streak only counts data wins that actually made fetch wait.
  always_comb begin
    streak_d = streak_q;
    if (!inst_req || grant_inst) streak_d = '0;
    else if (grant_data)         streak_d = sat_inc(streak_q, STREAK_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  always_comb begin
    sram_en    = grant_inst | grant_data;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_data) begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      if (data_wr) sram_we = data_wstrb;
    end else if (grant_inst) begin
      sram_addr = inst_addr;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign issue_tag    = grant_data ? TAG_DATA : TAG_INST;

  resp_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_resp_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (sram_en),
    .in_tag   (issue_tag),
    .out_valid(resp_valid),
    .out_tag  (resp_tag)
  );

  // Gated by reset so an access already in the last stage is dropped too.
  always_comb begin
    inst_data_ok = resp_valid && !reset && (resp_tag == TAG_INST);
    data_data_ok = resp_valid && !reset && (resp_tag == TAG_DATA);
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
  end

endmodule
